bitcoin_job_fetch: RTL and testbench

- CCI-P c0 read engine: fetches a contiguous ring of mining jobs from host memory, one 512-bit cache line per job, and hands them to the miner control FSM in request order.
- Counterpart of the AFU result writer: the writer pushes results out on c1, this block pulls work in on c0.
- Sits between the registered sRx/sTx channels and the miner job loader.
- Responses may return out of order; a tagged slot buffer restores order.

---
 rtl/bitcoin_pkg.sv | 45 ++++
 rtl/bitcoin_job_fetch_if.sv | 28 ++
 rtl/bitcoin_job_rob.sv | 60 ++++++
 rtl/bitcoin_job_fetch.sv | 123 ++++++++++++
 tb/tb_bitcoin_job_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the miner job fetch path: job line layout, fetch FSM
// states and the CCI-P c0 RDLINE_I request header.
package bitcoin_pkg;

  localparam int unsigned CL_W        = 512;
  localparam int unsigned CL_ADDR_W   = 42;
  localparam int unsigned MDATA_W     = 16;
  localparam int unsigned CNT_W       = 17;
  localparam int unsigned JOB_DATA_HI = 511;
  localparam int unsigned JOB_DATA_LO = 256;

  typedef struct packed {
    logic [255:0] data;
    logic [255:0] middata;
  } t_job;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} t_fetch_state;

  localparam logic [1:0] VC_VA        = 2'b00;
  localparam logic [1:0] CL_LEN_1     = 2'b00;
  localparam logic [3:0] REQ_RDLINE_I = 4'h0;

  typedef struct packed {
    logic [1:0]           vc_sel;
    logic [1:0]           rsvd1;
    logic [1:0]           cl_len;
    logic [3:0]           req_type;
    logic [5:0]           rsvd0;
    logic [CL_ADDR_W-1:0] address;
    logic [MDATA_W-1:0]   mdata;
  } t_c0_req_hdr;

  function automatic t_c0_req_hdr rdline_hdr(input logic [CL_ADDR_W-1:0] addr,
                                             input logic [MDATA_W-1:0]   mdata);
    t_c0_req_hdr h;
    h          = '0;
    h.vc_sel   = VC_VA;
    h.cl_len   = CL_LEN_1;
    h.req_type = REQ_RDLINE_I;
    h.address  = addr;
    h.mdata    = mdata;
    return h;
  endfunction

endpackage

// File: rtl/bitcoin_job_fetch_if.sv
// c0 read request/response channel plus the job hand-off to the miner control FSM.
interface bitcoin_job_fetch_if;
  import bitcoin_pkg::*;

  logic                 c0TxAlmFull;
  logic                 c0_req_valid;
  logic [CL_ADDR_W-1:0] c0_req_addr;
  logic [MDATA_W-1:0]   c0_req_mdata;
  logic                 c0_rsp_valid;
  logic [MDATA_W-1:0]   c0_rsp_mdata;
  logic [CL_W-1:0]      c0_rsp_data;
  logic                 job_valid;
  logic                 job_ready;
  logic [255:0]         job_data;
  logic [255:0]         job_middata;
  logic [15:0]          job_index;

  modport master (
    input  c0TxAlmFull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data, job_ready,
    output c0_req_valid, c0_req_addr, c0_req_mdata, job_valid, job_data, job_middata, job_index
  );

  modport slave (
    output c0TxAlmFull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data, job_ready,
    input  c0_req_valid, c0_req_addr, c0_req_mdata, job_valid, job_data, job_middata, job_index
  );

endinterface

// File: rtl/bitcoin_job_rob.sv
// Tagged reorder buffer: out-of-order line writes by slot tag, in-order read at the head slot.
module bitcoin_job_rob
  import bitcoin_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned TAG_W = $clog2(SLOTS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue,
  input  logic [TAG_W-1:0]   issue_tag,
  input  logic               rsp_valid,
  input  logic [MDATA_W-1:0] rsp_mdata,
  input  logic [CL_W-1:0]    rsp_data,
  input  logic               pop,
  input  logic [TAG_W-1:0]   head,
  output logic               head_filled,
  output t_job               head_job
);

  logic [SLOTS-1:0] pending_q, pending_d;
  logic [SLOTS-1:0] filled_q, filled_d;
  logic [CL_W-1:0]  line_q [SLOTS];
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_accept;

  assign rsp_tag = rsp_mdata[TAG_W-1:0];
  // Only tags we issued and still await are accepted; this also discards pre-reset stragglers.
  assign rsp_accept = rsp_valid && (rsp_mdata[MDATA_W-1:TAG_W] == '0) && pending_q[rsp_tag];

  always_comb begin
    pending_d = pending_q;
    filled_d  = filled_q;
    if (rsp_accept) begin
      pending_d[rsp_tag] = 1'b0;
      filled_d[rsp_tag]  = 1'b1;
    end
    if (issue) pending_d[issue_tag] = 1'b1;
    if (pop)   filled_d[head]       = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      filled_q  <= '0;
    end else begin
      pending_q <= pending_d;
      filled_q  <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_accept) line_q[rsp_tag] <= rsp_data;
  end

  assign head_filled      = filled_q[head];
  assign head_job.data    = line_q[head][JOB_DATA_HI:JOB_DATA_LO];
  assign head_job.middata = line_q[head][JOB_DATA_LO-1:0];

endmodule

// File: rtl/bitcoin_job_fetch.sv
// CCI-P c0 read engine: fetches num_jobs consecutive job lines from base_addr with up to
// SLOTS reads in flight and hands them to the miner in request order.
module bitcoin_job_fetch
  import bitcoin_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned TAG_W = $clog2(SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] base_addr,
  input  logic [15:0]          num_jobs,
  bitcoin_job_fetch_if.master  bus,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] SlotCredit = CNT_W'(SLOTS);

  t_fetch_state         state_q, state_d;
  logic [CL_ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]     num_q, req_cnt_q, pop_cnt_q;
  logic                 req_valid_q, done_q;
  logic [CL_ADDR_W-1:0] req_addr_q;
  logic [MDATA_W-1:0]   req_mdata_q;
  logic                 latch, issue, pop;
  logic                 head_filled;
  t_job                 head_job;
  t_c0_req_hdr          req_hdr;
  logic                 unused_hdr;

  assign pop = head_filled & bus.job_ready;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          latch   = 1'b1;
          state_d = (num_jobs == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        // Credit uses pre-pop counts; a same-cycle pop only frees the slot one cycle later.
        issue = (req_cnt_q < num_q) && ((req_cnt_q - pop_cnt_q) < SlotCredit) &&
                !bus.c0TxAlmFull;
        if (req_cnt_q == num_q) state_d = StDrain;
      end
      StDrain: begin
        if (pop_cnt_q == num_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign req_hdr = rdline_hdr(base_q + CL_ADDR_W'(req_cnt_q),
                              MDATA_W'(req_cnt_q[TAG_W-1:0]));
  assign unused_hdr = ^{req_hdr.vc_sel, req_hdr.rsvd1, req_hdr.cl_len, req_hdr.req_type,
                        req_hdr.rsvd0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      num_q       <= '0;
      req_cnt_q   <= '0;
      pop_cnt_q   <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        base_q    <= base_addr;
        num_q     <= {1'b0, num_jobs};
        req_cnt_q <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (issue) req_cnt_q <= req_cnt_q + 1'b1;
        if (pop)   pop_cnt_q <= pop_cnt_q + 1'b1;
      end
      req_valid_q <= issue;
      if (issue) begin
        req_addr_q  <= req_hdr.address;
        req_mdata_q <= req_hdr.mdata;
      end
      done_q <= (state_q == StDone);
    end
  end

  bitcoin_job_rob #(
    .SLOTS(SLOTS),
    .TAG_W(TAG_W)
  ) u_rob (
    .clk        (clk),
    .reset      (reset),
    .issue      (issue),
    .issue_tag  (req_cnt_q[TAG_W-1:0]),
    .rsp_valid  (bus.c0_rsp_valid),
    .rsp_mdata  (bus.c0_rsp_mdata),
    .rsp_data   (bus.c0_rsp_data),
    .pop        (pop),
    .head       (pop_cnt_q[TAG_W-1:0]),
    .head_filled(head_filled),
    .head_job   (head_job)
  );

  assign bus.c0_req_valid = req_valid_q;
  assign bus.c0_req_addr  = req_addr_q;
  assign bus.c0_req_mdata = req_mdata_q;
  assign bus.job_valid    = head_filled;
  assign bus.job_data     = head_filled ? head_job.data : '0;
  assign bus.job_middata  = head_filled ? head_job.middata : '0;
  assign bus.job_index    = pop_cnt_q[15:0];
  assign busy             = (state_q != StIdle);
  assign done             = done_q;

endmodule

// File: tb/tb_bitcoin_job_fetch.sv
// Directed bench for bitcoin_job_fetch with a queue/array level model checked every cycle.
module tb_bitcoin_job_fetch;
  import bitcoin_pkg::*;

  localparam int SLOTS = 4;
  localparam int TBW   = $clog2(SLOTS);

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [41:0] base_addr;
  logic [15:0] num_jobs;
  logic        busy, done;

  bitcoin_job_fetch_if bus ();

  bitcoin_job_fetch #(.SLOTS(SLOTS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .num_jobs (num_jobs),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state, written only by the monitor.
  bit          model_busy;
  logic [41:0] m_base;
  int          m_num;
  int          req_seen, pop_seen, done_seen;
  int          slot_job [SLOTS];
  bit          slot_live [SLOTS];
  bit          responded [256];
  logic [41:0] req_log_addr [64];
  logic [15:0] req_log_mdata [64];
  logic [15:0] pop_log [64];
  bit          prev_alm;
  logic [511:0] mline;
  logic [TBW-1:0] mtag;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_line(input string name, input logic [255:0] act,
                                   input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endfunction

  function automatic logic [511:0] exp_line(input logic [41:0] a);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = a[31:0] * 32'h9E37_79B1 + 32'(i);
    return l;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      model_busy = 1'b0;
      req_seen   = 0;
      pop_seen   = 0;
      prev_alm   = 1'b0;
      for (int i = 0; i < SLOTS; i++) slot_live[i] = 1'b0;
      for (int i = 0; i < 256; i++) responded[i] = 1'b0;
    end else begin
      if (bus.c0_req_valid) begin
        chk("req_addr", 64'(bus.c0_req_addr), 64'(m_base + 42'(req_seen)));
        chk("req_mdata", 64'(bus.c0_req_mdata), 64'(req_seen % SLOTS));
        chk("req_in_range", 64'(req_seen < m_num), 64'd1);
        chk("req_credit", 64'((req_seen - pop_seen) < SLOTS), 64'd1);
        chk("req_after_almfull", 64'(prev_alm), 64'd0);
        req_log_addr[req_seen % 64]  = bus.c0_req_addr;
        req_log_mdata[req_seen % 64] = bus.c0_req_mdata;
        slot_job[req_seen % SLOTS]   = req_seen;
        slot_live[req_seen % SLOTS]  = 1'b1;
        req_seen++;
      end
      chk("job_valid", 64'(bus.job_valid), 64'(responded[pop_seen % 256]));
      if (bus.job_valid) begin
        mline = exp_line(m_base + 42'(pop_seen));
        chk("job_index", 64'(bus.job_index), 64'(pop_seen));
        chk_line("job_data", bus.job_data, mline[511:256]);
        chk_line("job_middata", bus.job_middata, mline[255:0]);
        if (bus.job_ready) begin
          pop_log[pop_seen % 64] = bus.job_index;
          pop_seen++;
        end
      end
      if (bus.c0_rsp_valid) begin
        mtag = bus.c0_rsp_mdata[TBW-1:0];
        if (bus.c0_rsp_mdata[15:TBW] == '0 && slot_live[mtag]) begin
          responded[slot_job[mtag] % 256] = 1'b1;
          slot_live[mtag] = 1'b0;
        end
      end
      if (done) begin
        chk("done_all_popped", 64'(pop_seen), 64'(m_num));
        chk("done_while_running", 64'(model_busy), 64'd1);
        model_busy = 1'b0;
        done_seen++;
      end
      if (start && !model_busy) begin
        model_busy = 1'b1;
        m_base     = base_addr;
        m_num      = int'(num_jobs);
        req_seen   = 0;
        pop_seen   = 0;
        for (int i = 0; i < SLOTS; i++) slot_live[i] = 1'b0;
        for (int i = 0; i < 256; i++) responded[i] = 1'b0;
      end
      prev_alm = bus.c0TxAlmFull;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [41:0] b, input logic [15:0] n);
    base_addr = b;
    num_jobs  = n;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_raw(input logic [15:0] md, input logic [511:0] d);
    bus.c0_rsp_valid = 1'b1;
    bus.c0_rsp_mdata = md;
    bus.c0_rsp_data  = d;
    tick();
    bus.c0_rsp_valid = 1'b0;
  endtask

  task automatic send_rsp(input int tg);
    send_raw(16'(tg), exp_line(m_base + 42'(slot_job[tg])));
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int t = 0;
    while (req_seen < n && t < budget) begin
      tick();
      t++;
    end
    if (req_seen < n) timeout("wait_reqs");
  endtask

  // Answers the oldest outstanding read each cycle until the done pulse.
  task automatic serve(input int budget);
    int d0;
    int t;
    int best;
    int bj;
    d0 = done_seen;
    t  = 0;
    while (done_seen == d0 && t < budget) begin
      best = -1;
      bj   = 0;
      for (int i = 0; i < SLOTS; i++)
        if (slot_live[i] && (best < 0 || slot_job[i] < bj)) begin
          best = i;
          bj   = slot_job[i];
        end
      if (best >= 0) send_rsp(best);
      else tick();
      t++;
    end
    if (done_seen == d0) timeout("serve_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_jobs  = '0;
    bus.c0TxAlmFull  = 1'b0;
    bus.c0_rsp_valid = 1'b0;
    bus.c0_rsp_mdata = '0;
    bus.c0_rsp_data  = '0;
    bus.job_ready    = 1'b0;
    done_seen = 0;
    repeat (3) tick();
    chk("rst_req_valid", 64'(bus.c0_req_valid), 64'd0);
    chk("rst_req_addr", 64'(bus.c0_req_addr), 64'd0);
    chk("rst_job_valid", 64'(bus.job_valid), 64'd0);
    chk("rst_job_index", 64'(bus.job_index), 64'd0);
    chk_line("rst_job_data", bus.job_data, 256'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // In-order responses, consumer always ready.
    bus.job_ready = 1'b1;
    do_start(42'h1000, 16'd3);
    wait_reqs(3, 50);
    chk("t1_addr0", 64'(req_log_addr[0]), 64'h1000);
    chk("t1_addr2", 64'(req_log_addr[2]), 64'h1002);
    chk("t1_tag2", 64'(req_log_mdata[2]), 64'd2);
    chk("t1_busy", 64'(busy), 64'd1);
    d0 = done_seen;
    serve(100);
    chk("t1_pops", 64'(pop_seen), 64'd3);
    repeat (3) tick();
    chk("t1_done_once", 64'(done_seen - d0), 64'd1);
    chk("t1_idle", 64'(busy), 64'd0);

    // Credit limit with responses withheld, then one slot released.
    do_start(42'h1000, 16'd6);
    repeat (20) tick();
    chk("t2_credit_stall", 64'(req_seen), 64'd4);
    send_rsp(0);
    wait_reqs(5, 50);
    chk("t2_fifth_addr", 64'(req_log_addr[4]), 64'h1004);
    chk("t2_fifth_tag", 64'(req_log_mdata[4]), 64'd0);
    serve(300);
    chk("t2_pops", 64'(pop_seen), 64'd6);

    // Out-of-order responses 2,0,3,1.
    do_start(42'h2000, 16'd4);
    wait_reqs(4, 50);
    send_rsp(2);
    send_rsp(0);
    send_rsp(3);
    send_rsp(1);
    serve(100);
    chk("t3_pop_order1", 64'(pop_log[1]), 64'd1);
    chk("t3_pop_order3", 64'(pop_log[3]), 64'd3);

    // Almost-full window, plus a start pulse while busy that must be ignored.
    do_start(42'h3000, 16'd8);
    wait_reqs(2, 50);
    do_start(42'h9000, 16'd1);
    bus.c0TxAlmFull = 1'b1;
    tick();
    r0 = req_seen;
    repeat (9) tick();
    chk("t4_window_quiet", 64'(req_seen), 64'(r0));
    bus.c0TxAlmFull = 1'b0;
    serve(300);
    chk("t4_reqs", 64'(req_seen), 64'd8);
    chk("t4_pops", 64'(pop_seen), 64'd8);

    // Consumer stalls with a job waiting.
    bus.job_ready = 1'b0;
    do_start(42'h4000, 16'd6);
    wait_reqs(4, 50);
    repeat (3) tick();
    send_rsp(0);
    send_rsp(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", 64'(bus.job_valid), 64'd1);
      chk("t5_hold_index", 64'(bus.job_index), 64'd0);
    end
    chk("t5_credit_stop", 64'(req_seen), 64'd4);
    bus.job_ready = 1'b1;
    serve(300);
    chk("t5_pops", 64'(pop_seen), 64'd6);

    // Reset with reads outstanding; stale and foreign responses must be dropped.
    do_start(42'h5000, 16'd2);
    wait_reqs(2, 50);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_valid", 64'(bus.c0_req_valid), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    bus.c0TxAlmFull = 1'b1;
    do_start(42'h6000, 16'd2);
    send_raw(16'h0000, {16{32'hDEAD_BEEF}});
    send_raw(16'h0001, {16{32'hDEAD_BEEF}});
    repeat (3) tick();
    chk("t6_stale_dropped", 64'(bus.job_valid), 64'd0);
    bus.c0TxAlmFull = 1'b0;
    wait_reqs(2, 50);
    send_raw(16'h0100, {16{32'hBAD0_0000}});
    repeat (2) tick();
    chk("t6_upper_dropped", 64'(bus.job_valid), 64'd0);
    serve(100);
    chk("t6_pops", 64'(pop_seen), 64'd2);

    // Zero-length run: done two cycles after start, no requests.
    repeat (2) tick();
    do_start(42'h7000, 16'd0);
    @(negedge clk);
    chk("t7_done_early", 64'(done), 64'd0);
    @(negedge clk);
    chk("t7_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    chk("t7_done_late", 64'(done), 64'd0);
    chk("t7_no_reqs", 64'(req_seen), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
